// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed common-anode 7-segment display sharing one external decoder.
// New frame data is double-buffered and committed only at frame boundaries so a frame never tears.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  output logic [3:0]              bcd_o,
  input  logic [6:0]              segment_i,
  output logic [6:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] DRV_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {ST_GAP, ST_DRIVE} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [4*NUM_DIGITS-1:0] act_digits, pend_digits;
  logic [NUM_DIGITS-1:0]   act_blank, pend_blank, blank_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic                    pend_full;
  logic                    boundary, commit, accept;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    boundary  = 1'b0;
    if (!en_i) begin
      state_nxt = ST_GAP;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_DRIVE: begin
          if (cnt == DRV_LAST) begin
            cnt_nxt   = '0;
            state_nxt = ST_GAP;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt_nxt   = '0;
            state_nxt = ST_DRIVE;
            boundary  = (idx == IDX_LAST);
            idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = ST_GAP;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign commit = boundary && pend_full;
  assign accept = valid_i && !pend_full;

  // Anode pattern looks ahead so it reflects a commit landing on the same edge.
  always_comb begin
    blank_nxt = commit ? pend_blank : act_blank;
    an_nxt    = '1;
    if (state_nxt == ST_DRIVE && !blank_nxt[idx_nxt])
      an_nxt[idx_nxt] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_GAP;
      cnt        <= '0;
      idx        <= '0;
      pend_full  <= 1'b0;
      act_digits <= '0;
      act_blank  <= '1;
      an_o       <= '1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      an_o  <= an_nxt;
      if (commit) begin
        act_digits <= pend_digits;
        act_blank  <= pend_blank;
        pend_full  <= 1'b0;
      end else if (accept) begin
        pend_full <= 1'b1;
      end
    end
  end

  // Pending payload is only meaningful while pend_full is set, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      pend_digits <= digits_i;
      pend_blank  <= blank_i;
    end
  end

  assign ready_o = !pend_full;
  assign frame_o = boundary;
  assign bcd_o   = act_digits[{idx, 2'b00} +: 4];
  assign seg_o   = (&an_o) ? 7'h7F : segment_i;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl: a slot/timeline model of the scan predicts every output each cycle.
module tb_seg_scan_ctrl;

  localparam int N = 4;
  localparam int R = 4;
  localparam int G = 2;
  localparam int P = R + G;

  logic        clk = 1'b0;
  logic        rst_ni, en, valid, ready, frame;
  logic [15:0] digits;
  logic [3:0]  blank, bcd, an;
  logic [6:0]  segment, seg;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GAP_CYCLES(G)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en), .valid_i(valid), .ready_o(ready),
    .digits_i(digits), .blank_i(blank), .bcd_o(bcd), .segment_i(segment),
    .seg_o(seg), .an_o(an), .frame_o(frame)
  );

  // Active-low hex decoder, bit0 = segment a.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40; 4'h1: hex7 = 7'h79; 4'h2: hex7 = 7'h24; 4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19; 4'h5: hex7 = 7'h12; 4'h6: hex7 = 7'h02; 4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h10; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46; 4'hD: hex7 = 7'h21; 4'hE: hex7 = 7'h06; default: hex7 = 7'h0E;
    endcase
  endfunction

  assign segment = hex7(bcd);

  // Timeline model: slot k = G dark cycles, then R cycles driving digit k.
  int          m_k, m_pos;
  logic [15:0] m_act_d, m_pend_d;
  logic [3:0]  m_act_b, m_pend_b;
  logic        m_pfull;
  int          n_chk, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_k     = 1;
    m_pos   = 0;
    m_act_d = '0;
    m_act_b = '1;
    m_pfull = 1'b0;
  endtask

  task automatic check_outputs();
    logic       drive;
    logic [3:0] ean, ebcd;
    logic [6:0] eseg;
    int         eidx;
    drive = (m_pos >= G);
    eidx  = drive ? m_k : (m_k + N - 1) % N;
    ean   = 4'hF;
    if (drive && !m_act_b[m_k]) ean = ~(4'b0001 << m_k);
    ebcd  = m_act_d[eidx*4 +: 4];
    eseg  = (ean == 4'hF) ? 7'h7F : hex7(ebcd);
    chk("an", 32'(an), 32'(ean));
    chk("seg", 32'(seg), 32'(eseg));
    chk("bcd", 32'(bcd), 32'(ebcd));
    chk("frame", 32'(frame), 32'(en && m_k == 0 && m_pos == G - 1));
    chk("ready", 32'(ready), 32'(!m_pfull));
  endtask

  task automatic model_edge(output logic took);
    logic fr;
    fr   = en && m_k == 0 && m_pos == G - 1;
    took = valid && !m_pfull;
    if (fr && m_pfull) begin
      m_act_d = m_pend_d;
      m_act_b = m_pend_b;
      m_pfull = 1'b0;
    end
    if (took) begin
      m_pend_d = digits;
      m_pend_b = blank;
      m_pfull  = 1'b1;
    end
    if (en) begin
      m_pos++;
      if (m_pos == P) begin
        m_pos = 0;
        m_k   = (m_k + 1) % N;
      end
    end else begin
      if (m_pos >= G) m_k = (m_k + 1) % N;
      m_pos = 0;
    end
  endtask

  initial begin
    logic took, did_rst;
    int   en_low;
    n_chk   = 0;
    n_err   = 0;
    rst_ni  = 1'b0;
    en      = 1'b0;
    valid   = 1'b0;
    digits  = '0;
    blank   = '0;
    en_low  = 0;
    took    = 1'b0;
    did_rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1 check_outputs();
    rst_ni = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (took) valid = 1'b0;
      if (cyc < 48) begin
        en    = 1'b1;
        valid = 1'b0;
      end else begin
        if (cyc == 48) begin
          valid  = 1'b1;
          digits = 16'h1234;
          blank  = 4'h0;
        end else if (!valid && $urandom_range(0, 15) == 0) begin
          valid  = 1'b1;
          digits = 16'($urandom);
          blank  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        end
        if (en) begin
          if ($urandom_range(0, 49) == 0) begin
            en     = 1'b0;
            en_low = $urandom_range(1, 12);
          end
        end else begin
          en_low--;
          if (en_low <= 0) en = 1'b1;
        end
        if (!did_rst && cyc > 1500 && m_pfull) begin
          did_rst = 1'b1;
          rst_ni  = 1'b0;
          valid   = 1'b0;
          #1;
          model_reset();
          check_outputs();
          repeat (2) @(negedge clk);
          rst_ni = 1'b1;
        end
      end
      #1 check_outputs();
      @(posedge clk);
      model_edge(took);
      @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
